// File: rtl/keypad_responder_pkg.sv
// Shared keypad definitions: FSM state encoding, key-code field positions, bounce LFSR taps.
// The scanner imports the same key-code field positions so both ends agree on the layout.
package keypad_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int ROW_MSB = 3;
  localparam int ROW_LSB = 2;
  localparam int COL_MSB = 1;
  localparam int COL_LSB = 0;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [3:0] col_onehot(input logic [1:0] col);
    return 4'b0001 << col;
  endfunction

endpackage

// File: rtl/keypad_responder_bounce_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; one new contact-noise bit per clock, reloads seed on rst.
// No handshake: the consumer samples lfsr_bit whenever it needs noise.
module keypad_bounce_lfsr
  import keypad_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic        lfsr_bit
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= seed;
    end else begin
      r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
    end
  end

  assign lfsr_bit = r_lfsr[0];

endmodule

// File: rtl/keypad_responder.sv
// 4x4 keypad model: holds one key for max(cmd_hold,1) cycles then stays released GAP_CYCLES; col_out lags row_sweep by 1 clk.
// cmd_ready only in IDLE, commands offered while busy are ignored; KEYPAD_BOUNCE_EN adds LFSR contact bounce.
module keypad_responder
  import keypad_responder_pkg::*;
#(
  parameter int          HOLD_W        = 24,
  parameter int          GAP_CYCLES    = 1000,
  parameter int          BOUNCE_CYCLES = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        row_sweep,
  output logic [3:0]        col_out,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              busy,
  output logic              done
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int CNT_W = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_key;
  logic [3:0]       r_col;
  logic             r_done, w_done_nxt;
  logic             w_accept;
  logic             w_clean;
  logic             w_contact;

  assign w_accept = cmd_valid && (r_state == ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_clean     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_PRESS;
          // A zero hold still gives a one-cycle press; no wrap at the maximum hold.
          w_cnt_nxt   = (cmd_hold == '0) ? '0 : CNT_W'(cmd_hold - HOLD_W'(1));
        end
      end
      ST_PRESS: begin
        w_clean = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef KEYPAD_BOUNCE_EN
  localparam int PH_W = $clog2(BOUNCE_CYCLES + 1);

  logic [PH_W-1:0] r_phase;
  logic            w_lfsr_bit;
  logic            w_in_window;

  keypad_bounce_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .seed     (LFSR_SEED),
    .lfsr_bit (w_lfsr_bit)
  );

  assign w_in_window = (r_phase < PH_W'(BOUNCE_CYCLES));

  // Cycles elapsed in the current phase, saturating once the bounce window is over.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
    end else if (w_state_nxt != r_state) begin
      r_phase <= '0;
    end else if (w_in_window) begin
      r_phase <= r_phase + PH_W'(1);
    end
  end

  assign w_contact = ((r_state == ST_PRESS) || (r_state == ST_GAP)) && w_in_window
                     ? w_lfsr_bit : w_clean;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{LFSR_SEED, 32'(BOUNCE_CYCLES)};
  assign w_contact    = w_clean;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_key   <= '0;
      r_done  <= 1'b0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) r_key <= cmd_key;
      r_col   <= (w_contact && row_sweep[r_key[ROW_MSB:ROW_LSB]])
                 ? col_onehot(r_key[COL_MSB:COL_LSB]) : 4'b0000;
    end
  end

  assign col_out   = r_col;
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_keypad_responder.sv
// Randomised scoreboard bench for keypad_responder (clean-contact build).
module tb_keypad_responder;

  localparam int HOLD_W = 8;
  localparam int GAP    = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        row_sweep;
  logic [3:0]        col_out;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_key;
  logic [HOLD_W-1:0] cmd_hold;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  keypad_responder #(
    .HOLD_W        (HOLD_W),
    .GAP_CYCLES    (GAP),
    .BOUNCE_CYCLES (8),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_sweep (row_sweep),
    .col_out   (col_out),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_key   (cmd_key),
    .cmd_hold  (cmd_hold),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [3:0] col;
    logic       rdy;
    logic       bsy;
    logic       dn;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a press is a time interval. Accept at cycle a with effective hold h
  // means contact over cycles a+1..a+h, busy over a+1..a+h+GAP, done and IDLE at a+h+GAP+1.
  int         cyc = 0;
  bit         a_vld = 1'b0;
  int         a_c = 0;
  int         h_c = 1;
  int         free_c = 0;
  logic [3:0] m_key = 4'd0;
  bit         one_shot = 1'b1;

  task automatic tick();
    bit         contact;
    bit         accept;
    logic [3:0] col_next;
    exp_t       e;
    contact  = a_vld && (cyc >= a_c + 1) && (cyc <= a_c + h_c);
    col_next = (!rst && contact && row_sweep[m_key[3:2]]) ? (4'b0001 << m_key[1:0]) : 4'b0000;
    accept   = !rst && cmd_valid && (cyc >= free_c);
    if (rst) begin
      a_vld  = 1'b0;
      free_c = cyc + 1;
    end else if (accept) begin
      a_vld  = 1'b1;
      a_c    = cyc;
      h_c    = (cmd_hold == '0) ? 1 : int'(cmd_hold);
      free_c = cyc + h_c + GAP + 1;
      m_key  = cmd_key;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (accept && one_shot) cmd_valid = 1'b0;
    e.col = col_next;
    e.rdy = (cyc >= free_c);
    e.bsy = a_vld && (cyc >= a_c + 1) && (cyc <= a_c + h_c + GAP);
    e.dn  = a_vld && (cyc == a_c + h_c + GAP + 1);
    e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic set_sweep(input int mode, input logic [3:0] fixed);
    case (mode)
      0:       row_sweep = 4'b0001 << ((cyc / 4) % 4);
      1:       row_sweep = fixed;
      default: row_sweep = 4'($urandom_range(0, 15));
    endcase
  endtask

  task automatic run(input int n, input int mode, input logic [3:0] fixed);
    for (int i = 0; i < n; i++) begin
      set_sweep(mode, fixed);
      tick();
    end
  endtask

  task automatic issue(input logic [3:0] key, input logic [HOLD_W-1:0] hold, input bit one);
    cmd_key   = key;
    cmd_hold  = hold;
    cmd_valid = 1'b1;
    one_shot  = one;
  endtask

  task automatic chk(input string name, input int c, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, c, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("col_out",   e.cyc, col_out,          e.col);
      chk("cmd_ready", e.cyc, {3'b0, cmd_ready}, {3'b0, e.rdy});
      chk("busy",      e.cyc, {3'b0, busy},      {3'b0, e.bsy});
      chk("done",      e.cyc, {3'b0, done},      {3'b0, e.dn});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_key   = 4'd0;
    cmd_hold  = '0;
    row_sweep = 4'd0;
    run(2, 1, 4'b0000);
    rst = 1'b0;

    run(16, 0, 4'b0000);

    issue(4'b0110, 8'd20, 1'b1);
    run(40, 0, 4'b0000);

    issue(4'b1111, 8'd0, 1'b1);
    run(12, 1, 4'b1000);

    // Second command held high while the first is still busy.
    issue(4'b0101, 8'd10, 1'b0);
    run(3, 0, 4'b0000);
    cmd_key  = 4'b1010;
    cmd_hold = 8'd6;
    one_shot = 1'b1;
    run(40, 2, 4'b0000);

    issue(4'b0000, 8'd100, 1'b1);
    run(5, 1, 4'b0001);
    rst = 1'b1;
    run(1, 1, 4'b0001);
    rst = 1'b0;
    run(3, 1, 4'b0001);
    issue(4'b1101, 8'd7, 1'b1);
    run(20, 0, 4'b0000);

    issue(4'b0111, 8'hFF, 1'b1);
    run(270, 2, 4'b0000);

    for (int i = 0; i < 1500; i++) begin
      if (!cmd_valid && ($urandom_range(0, 3) == 0))
        issue(4'($urandom_range(0, 15)), HOLD_W'($urandom_range(0, 30)), 1'b1);
      rst = ($urandom_range(0, 199) == 0);
      set_sweep(2, 4'b0000);
      tick();
    end
    rst       = 1'b0;
    cmd_valid = 1'b0;
    run(10, 2, 4'b0000);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_responder.md
Name: keypad_responder

Overview:
- Synthesizable 4x4 matrix-keypad model: the far end of the row-sweep/column-sense interface used by the midterm keypad scanner.
- Watches the scanner's `row_sweep` output and drives the column lines the scanner reads as `in`, as if a physical key were pressed.
- Key presses are queued by a valid/ready command port, each with a hold time.
- Used for FPGA loopback self-test and as a cycle-accurate stimulus source in benches, replacing hand-timed `in` waveforms.

Parameters:
- HOLD_W, 24, width of the hold-duration field in clock cycles.
- GAP_CYCLES, 1000, minimum released time after each press before the next command is accepted (>=1).
- BOUNCE_CYCLES, 64, length of each bounce window (used only with the optional feature).
- LFSR_SEED, 16'hACE1, non-zero reset seed of the bounce LFSR.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- row_sweep  in  4  row drive from the scanner; active-high, normally one-hot.
- col_out  out  4  column sense to the scanner; active-high; 0 when no contact.
- cmd_valid  in  1  press request valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_key  in  4  key code: row = cmd_key[3:2], col = cmd_key[1:0].
- cmd_hold  in  HOLD_W  press duration in cycles; 0 is treated as 1.
- busy  out  1  high in PRESS or GAP.
- done  out  1  one-cycle pulse at the end of GAP.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; col_out=0, busy=0, done=0, cmd_ready=1; counters=0; LFSR=LFSR_SEED. Reset asserted mid-press drops contact on the next edge.
- Handshake: a command is accepted on a clk edge where cmd_valid && cmd_ready. key_r and hold_r latch at that edge; cmd_ready falls in the same edge. Commands presented while busy are not accepted and are not stored.
- States:
  - IDLE -> PRESS on accept; cnt = max(cmd_hold,1) - 1.
  - PRESS: contact=1; decrement cnt each cycle; at cnt==0 go to GAP with cnt = GAP_CYCLES-1.
  - GAP: contact=0; decrement cnt; at cnt==0 go to IDLE and pulse done for that one cycle.
- Press length: contact is high for exactly max(cmd_hold,1) cycles, starting the cycle after accept.
- Column drive:
  - Registered: col_out <= (contact && row_sweep[key_r[3:2]]) ? (4'b1 << key_r[1:0]) : 4'b0000.
  - Latency is one clock from row_sweep to col_out.
  - If row_sweep is not one-hot, col_out asserts whenever the pressed row's bit is set (physical wired behaviour).
  - If row_sweep = 0, col_out = 0.
- Only one key is ever held; col_out is never multi-bit.
- Boundary cases:
  - cmd_hold = {HOLD_W{1}}: the counter does not overflow.
  - GAP_CYCLES = 1: done fires one cycle after contact release.
  - Back-to-back commands: the earliest next accept is the cycle done is high (IDLE reached).

Optional Feature:
- Macro: KEYPAD_BOUNCE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - In the first BOUNCE_CYCLES cycles of PRESS, contact = LFSR[0].
  - In the first BOUNCE_CYCLES cycles of GAP, contact = LFSR[0].
  - Outside those windows, contact is a clean 1 in PRESS and a clean 0 in GAP.
  - If the hold or gap is shorter than BOUNCE_CYCLES, that whole phase bounces.
- Undefined: contact is clean; the LFSR and bounce logic are not built.

Decomposition:
- Shared definitions file keypad_defs.vh:
  - state encodings IDLE/PRESS/GAP;
  - key-code field positions (ROW_MSB/LSB, COL_MSB/LSB);
  - LFSR tap constant.
- The scanner reuses the key-code field definitions.
- One sub-module: keypad_bounce_lfsr (clk, rst, seed → bit), instantiated only under KEYPAD_BOUNCE_EN.

Test Plan:
- Reset then idle, with row_sweep cycling 0001→0010→0100→1000 every 4 clocks → col_out = 0000 throughout; cmd_ready=1; busy=0.
- cmd_key=4'b0110 (row 1, col 2), cmd_hold=20, sweep as above → col_out=0100 exactly one clock after each row_sweep=0010 cycle inside the 20-cycle window, 0000 otherwise; done pulses GAP_CYCLES cycles after release.
- cmd_hold=0, cmd_key=4'b1111, row_sweep held at 1000 → col_out=1000 for exactly 1 cycle.
- Second command while busy (cmd_valid held high) → not accepted until the cycle done=1; the following press starts the next cycle, with no lost or duplicated press.
- rst asserted at cycle 5 of a 100-cycle press → next edge: col_out=0, busy=0, cmd_ready=1; a fresh command then behaves normally.
- With KEYPAD_BOUNCE_EN, BOUNCE_CYCLES=8, hold=30, row_sweep=0100, key=4'b1001 → col_out toggles between 0010 and 0000 following LFSR[0] for 8 cycles, then holds 0010 for 22 cycles, then bounces 8 cycles into GAP; the sequence is identical after re-reset.
